// File: rtl/mat_a_loader.sv
// -----------------------------------------------------------------------------
// mat_a_loader
//
// Front end of the A-matrix transpose-FIFO bank. Host words arriving over a
// valid/ready handshake are packed into DIM-element signed rows. Each finished
// row is written into the bank with a one-cycle WrEn strobe (Arow/Ain). After
// all DIM rows are in, the bank shift enable is held for the 3*DIM-2 cycle
// systolic skew window, and then a one-cycle done pulse is raised.
//
// Parameters
//   BITS_AB : width of one signed matrix element
//   DIM     : rows per load and elements per row
//   WORD_W  : host word width; DIM*BITS_AB must be a whole multiple of WORD_W
//
// Ports
//   clk      : clock, rising edge
//   rst      : synchronous, active-high reset (aborts any job in progress)
//   start    : begin a load+stream job (sampled only while idle)
//   in_valid : in_data carries a word
//   in_data  : packed element data, element k of a row at bits [k*BITS_AB +: BITS_AB]
//   in_ready : loader accepts in_data this cycle
//   Ain      : row data to the FIFO bank
//   Arow     : index of the row being written
//   WrEn     : row write strobe
//   en       : FIFO bank shift enable
//   busy     : job in progress
//   done     : one-cycle completion pulse
//
// All outputs are registered.
// -----------------------------------------------------------------------------
module mat_a_loader #(
  parameter int BITS_AB = 8,
  parameter int DIM     = 8,
  parameter int WORD_W  = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      in_valid,
  input  logic [WORD_W-1:0]         in_data,
  output logic                      in_ready,
  output logic signed [BITS_AB-1:0] Ain [DIM],
  output logic [$clog2(DIM)-1:0]    Arow,
  output logic                      WrEn,
  output logic                      en,
  output logic                      busy,
  output logic                      done
);

  localparam int ROW_W      = DIM * BITS_AB;
  localparam int WPR        = ROW_W / WORD_W;
  // A one-word row still needs a legal (1-bit) counter; it simply stays at 0.
  localparam int WCW        = (WPR > 1) ? $clog2(WPR) : 1;
  localparam int RCW        = $clog2(DIM);
  localparam int STREAM_LEN = 3 * DIM - 2;
  localparam int SCW        = $clog2(3 * DIM - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_FLUSH  = 3'd2,
    S_STREAM = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  // Control state
  state_t           state_q,      state_d;
  logic [WCW-1:0]   word_cnt_q,   word_cnt_d;
  logic [RCW-1:0]   row_cnt_q,    row_cnt_d;
  logic [SCW-1:0]   stream_cnt_q, stream_cnt_d;

  // Row assembly buffer and the separate output row register. Keeping Ain
  // apart from the assembly buffer is what lets words keep flowing while the
  // previous row is being written.
  logic [ROW_W-1:0]          row_q, row_d;
  logic signed [BITS_AB-1:0] ain_q [DIM];
  logic signed [BITS_AB-1:0] ain_d [DIM];
  logic [RCW-1:0]            arow_q, arow_d;

  // Registered handshake / status outputs
  logic in_ready_q, in_ready_d;
  logic wren_q,     wren_d;
  logic en_q,       en_d;
  logic busy_q,     busy_d;
  logic done_q,     done_d;

  logic accept;

  // ---------------------------------------------------------------------------
  // Next-state and next-output computation
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    word_cnt_d   = word_cnt_q;
    row_cnt_d    = row_cnt_q;
    stream_cnt_d = stream_cnt_q;
    row_d        = row_q;
    ain_d        = ain_q;
    arow_d       = arow_q;
    wren_d       = 1'b0;

    // in_ready_q is high exactly in LOAD, so this is the LOAD handshake.
    accept = in_valid & in_ready_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_LOAD;
          word_cnt_d = '0;
          row_cnt_d  = '0;
        end
      end

      S_LOAD: begin
        if (accept) begin
          row_d[word_cnt_q * WORD_W +: WORD_W] = in_data;
          if (word_cnt_q == WCW'(WPR - 1)) begin
            // Row complete: publish it, including the word accepted now.
            for (int k = 0; k < DIM; k++) begin
              ain_d[k] = row_d[k * BITS_AB +: BITS_AB];
            end
            arow_d     = row_cnt_q;
            wren_d     = 1'b1;
            word_cnt_d = '0;
            row_cnt_d  = row_cnt_q + 1'b1;
            if (row_cnt_q == RCW'(DIM - 1)) begin
              state_d = S_FLUSH;
            end
          end else begin
            word_cnt_d = word_cnt_q + 1'b1;
          end
        end
      end

      // The last row's WrEn is visible during this cycle; shifting waits.
      S_FLUSH: begin
        state_d      = S_STREAM;
        stream_cnt_d = '0;
      end

      S_STREAM: begin
        if (stream_cnt_q == SCW'(STREAM_LEN - 1)) begin
          state_d = S_DONE;
        end else begin
          stream_cnt_d = stream_cnt_q + 1'b1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Status outputs follow the state being entered so they are registered
    // and aligned with it.
    in_ready_d = (state_d == S_LOAD);
    en_d       = (state_d == S_STREAM);
    done_d     = (state_d == S_DONE);
    busy_d     = (state_d != S_IDLE);
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      word_cnt_q   <= '0;
      row_cnt_q    <= '0;
      stream_cnt_q <= '0;
      row_q        <= '0;
      for (int k = 0; k < DIM; k++) begin
        ain_q[k] <= '0;
      end
      arow_q       <= '0;
      in_ready_q   <= 1'b0;
      wren_q       <= 1'b0;
      en_q         <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      word_cnt_q   <= word_cnt_d;
      row_cnt_q    <= row_cnt_d;
      stream_cnt_q <= stream_cnt_d;
      row_q        <= row_d;
      ain_q        <= ain_d;
      arow_q       <= arow_d;
      in_ready_q   <= in_ready_d;
      wren_q       <= wren_d;
      en_q         <= en_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign in_ready = in_ready_q;
  assign Ain      = ain_q;
  assign Arow     = arow_q;
  assign WrEn     = wren_q;
  assign en       = en_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule
